mdu_sched: RTL and testbench

Multiply/divide scheduler and pipeline stall controller for the 5-stage core. Tracks the multi-cycle HI/LO unit (mult/multu/div/divu), holds its busy countdown, and combines MDU structural hazards with the external data-hazard stall into the enable and bubble controls for the PC, the D-stage register and the E-stage register. Sits beside the E stage; its outputs drive the PC enable, the D-register enable and the E-register reset (bubble insertion).

---
 rtl/mdu_sched.sv | 82 ++++++++
 tb/tb_mdu_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: HI/LO multiply/divide busy tracker and pipeline stall controller
// Ports: startE/opE start an MDU op from E; mdUseD flags an MDU user in D;
// hazardStall is the external data-hazard stall; busy/opOut/resultWe report
// the MDU; pcEn/dEn/eFlush drive the PC enable, D enable and E bubble.
// Optional HAZARD_PERF_CNT_EN adds stallCnt/mdStallCnt cycle counters.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startE,
  input  logic [1:0] opE,
  input  logic       mdUseD,
  input  logic       hazardStall,
  output logic       busy,
  output logic [1:0] opOut,
  output logic       resultWe,
  output logic       pcEn,
  output logic       dEn,
  output logic       eFlush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stallCnt,
  output logic [31:0] mdStallCnt
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] op_n;
  logic we_n, md_stall, stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opOut    <= '0;
      resultWe <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      opOut    <= op_n;
      resultWe <= we_n;
    end
  end
  // a start arriving while busy is dropped; the countdown never pauses for stalls
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = opOut;
    we_n    = 1'b0;
    if (state == IDLE && startE) begin
      state_n = RUN;
      cnt_n   = opE[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      op_n    = opE;
    end else if (state == RUN) begin
      cnt_n = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_n = IDLE;
        we_n    = 1'b1;
      end
    end
  end
  assign busy     = state == RUN;
  assign md_stall = mdUseD & (startE | busy);
  assign stall    = hazardStall | md_stall;
  assign pcEn     = ~stall;
  assign dEn      = ~stall;
  assign eFlush   = stall;
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt   <= '0;
      mdStallCnt <= '0;
    end else begin
      stallCnt   <= stallCnt + 32'(stall);
      mdStallCnt <= mdStallCnt + 32'(md_stall);
    end
  end
`endif
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed vector bench for mdu_sched
module tb_mdu_sched;
  logic clk = 1'b0, reset = 1'b1, startE = 1'b0, mdUseD = 1'b0, hazardStall = 1'b0;
  logic [1:0] opE = 2'b00;
  logic busy, resultWe, pcEn, dEn, eFlush;
  logic [1:0] opOut;
  int total = 0, bad = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, mdStallCnt;
`endif
  mdu_sched dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .mdUseD(mdUseD),
    .hazardStall(hazardStall), .busy(busy), .opOut(opOut), .resultWe(resultWe),
    .pcEn(pcEn), .dEn(dEn), .eFlush(eFlush)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCnt(stallCnt), .mdStallCnt(mdStallCnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st;
    logic [1:0] op;
    logic md;
    logic hz;
    logic [6:0] exp;
  } vec_t;
  vec_t vq[$];
  function automatic logic [6:0] ex(input logic b, input logic [1:0] o, input logic w, input logic s);
    return {b, o, w, ~s, ~s, s};
  endfunction
  function automatic void add(input logic st, input logic [1:0] op, input logic md, input logic hz, input logic [6:0] e);
    vq.push_back('{st, op, md, hz, e});
  endfunction
  task automatic step(input logic rs, input logic st, input logic [1:0] op, input logic md, input logic hz);
    @(negedge clk);
    reset = rs; startE = st; opE = op; mdUseD = md; hazardStall = hz;
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask
  function automatic logic [6:0] outs();
    return {busy, opOut, resultWe, pcEn, dEn, eFlush};
  endfunction
  initial begin
    // mult: start, 5 busy, strobe
    add(0, 2'b00, 0, 0, ex(0, 2'b00, 0, 0));
    add(1, 2'b00, 0, 0, ex(0, 2'b00, 0, 0));
    for (int i = 0; i < 5; i++) add(0, 2'b00, 0, 0, ex(1, 2'b00, 0, 0));
    add(0, 2'b00, 0, 0, ex(0, 2'b00, 1, 0));
    add(0, 2'b00, 0, 0, ex(0, 2'b00, 0, 0));
    // one-cycle hazard stall while idle
    add(0, 2'b00, 0, 1, ex(0, 2'b00, 0, 1));
    add(0, 2'b00, 0, 0, ex(0, 2'b00, 0, 0));
    // divu with mdUseD held: stall during start and all 10 busy cycles
    add(1, 2'b11, 1, 0, ex(0, 2'b00, 0, 1));
    for (int i = 0; i < 10; i++) add(0, 2'b00, 1, 0, ex(1, 2'b11, 0, 1));
    // release + back-to-back multu start in the strobe cycle
    add(1, 2'b01, 0, 0, ex(0, 2'b11, 1, 0));
    add(0, 2'b00, 0, 0, ex(1, 2'b01, 0, 0));
    add(1, 2'b10, 0, 0, ex(1, 2'b01, 0, 0));
    add(0, 2'b00, 0, 1, ex(1, 2'b01, 0, 1));
    add(0, 2'b00, 0, 0, ex(1, 2'b01, 0, 0));
    add(0, 2'b00, 0, 0, ex(1, 2'b01, 0, 0));
    add(0, 2'b00, 0, 0, ex(0, 2'b01, 1, 0));
    add(0, 2'b00, 0, 0, ex(0, 2'b01, 0, 0));
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("reset", 32'(outs()), 32'(ex(0, 2'b00, 0, 0)));
    foreach (vq[i]) begin
      step(0, vq[i].st, vq[i].op, vq[i].md, vq[i].hz);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
    end
    // div aborted by reset on its third busy cycle
    step(0, 1, 2'b10, 0, 0);
    chk("abort_start", 32'(outs()), 32'(ex(0, 2'b01, 0, 0)));
    step(0, 0, 2'b00, 0, 0);
    chk("abort_b1", 32'(outs()), 32'(ex(1, 2'b10, 0, 0)));
    step(0, 0, 2'b00, 0, 0);
    chk("abort_b2", 32'(outs()), 32'(ex(1, 2'b10, 0, 0)));
    step(1, 0, 2'b00, 0, 0);
    chk("abort_b3", 32'(outs()), 32'(ex(1, 2'b10, 0, 0)));
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 2'b00, 0, 0);
      chk($sformatf("abort_idle%0d", i), 32'(outs()), 32'(ex(0, 2'b00, 0, 0)));
    end
    step(0, 1, 2'b00, 0, 0);
    chk("post_start", 32'(outs()), 32'(ex(0, 2'b00, 0, 0)));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 2'b00, 0, 0);
      chk($sformatf("post_busy%0d", i), 32'(outs()), 32'(ex(1, 2'b00, 0, 0)));
    end
    step(0, 0, 2'b00, 0, 0);
    chk("post_we", 32'(outs()), 32'(ex(0, 2'b00, 1, 0)));
    step(0, 0, 2'b00, 0, 0);
    chk("post_idle", 32'(outs()), 32'(ex(0, 2'b00, 0, 0)));
`ifdef HAZARD_PERF_CNT_EN
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("cnt_clr", stallCnt | mdStallCnt, 32'd0);
    step(0, 1, 2'b11, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 1, 0);
    step(0, 0, 2'b00, 0, 0);
    chk("stallCnt", stallCnt, 32'd11);
    chk("mdStallCnt", mdStallCnt, 32'd11);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
